// File: rtl/my_pwm_v1_0.sv
`timescale 1ns/1ps
// my_pwm_v1_0 - three-channel PWM generator behind an AXI4-Lite slave.
//
// Each channel has a W-bit period counter that runs 0..LIM and wraps, so the
// period is LIM+1 cycles. The channel output is high while cnt < DN. DN and
// LIM are written into shadow registers; a running channel picks them up at
// its period wrap, and a stopped channel picks them up at once.
//
// Register map (byte offset, decoded on addr[5:2]):
//   0x00 CST   [2:0] channel enable, [6:4] IRQ enable (MYPWM_IRQ_EN only)
//   0x04 STAT  [2:0] sticky wrap flags, write-1-to-clear (MYPWM_IRQ_EN only)
//   0x08 DN0   0x0C LIM0   0x10 DN1   0x14 LIM1   0x18 DN2   0x1C LIM2
//   other offsets read 0 and ignore writes.
//
// Optional feature macro: MYPWM_IRQ_EN adds STAT flags, CST[6:4] and irq.
//
// Ports:
//   s00_axi_aclk      single clock for bus and PWM logic
//   s00_axi_aresetn   asynchronous active-low reset
//   s00_axi_aw*/w*/b* AXI4-Lite write address, data and response channels
//   s00_axi_ar*/r*    AXI4-Lite read address and data channels
//   pwm_out[2:0]      registered PWM outputs, bit i = channel i
//   irq               level interrupt, |(STAT & CST[6:4]) (MYPWM_IRQ_EN only)
module my_pwm_v1_0 #(
  parameter int W                    = 12,
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 6
) (
  input  logic                                s00_axi_aclk,
  input  logic                                s00_axi_aresetn,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                          s00_axi_awprot,
  input  logic                                s00_axi_awvalid,
  output logic                                s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                                s00_axi_wvalid,
  output logic                                s00_axi_wready,
  output logic [1:0]                          s00_axi_bresp,
  output logic                                s00_axi_bvalid,
  input  logic                                s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                          s00_axi_arprot,
  input  logic                                s00_axi_arvalid,
  output logic                                s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                          s00_axi_rresp,
  output logic                                s00_axi_rvalid,
  input  logic                                s00_axi_rready,
  output logic [2:0]                          pwm_out
`ifdef MYPWM_IRQ_EN
  ,
  output logic                                irq
`endif
);

  localparam int DW = C_S00_AXI_DATA_WIDTH;
  localparam int BW = DW / 8;

`ifdef MYPWM_IRQ_EN
  localparam logic [6:0] CST_MASK = 7'h77;
`else
  localparam logic [6:0] CST_MASK = 7'h07;
`endif

  // Reset: asserted asynchronously, released synchronously
  logic rst_meta;
  logic rst_n_int;

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      rst_meta  <= 1'b0;
      rst_n_int <= 1'b0;
    end else begin
      rst_meta  <= 1'b1;
      rst_n_int <= rst_meta;
    end
  end

  // Register state
  logic [6:0]   cst;
  logic [2:0]   stat;
  logic [W-1:0] dn_sh  [3];
  logic [W-1:0] lim_sh [3];
  logic [W-1:0] dn_act [3];
  logic [W-1:0] lim_act[3];
  logic [W-1:0] cnt    [3];
  logic [2:0]   wrap;

  logic         wr_hs;
  logic         rd_hs;
  logic [3:0]   waddr;
  logic [3:0]   raddr;
  logic [DW-1:0] wr_word;

  // Read view of the register file; fields are zero-extended
  function automatic logic [DW-1:0] reg_rd(input logic [3:0] a);
    logic [DW-1:0] r;
    r = '0;
    case (a)
      4'd0: r[6:0]   = cst;
      4'd1: r[2:0]   = stat;
      4'd2: r[W-1:0] = dn_sh[0];
      4'd3: r[W-1:0] = lim_sh[0];
      4'd4: r[W-1:0] = dn_sh[1];
      4'd5: r[W-1:0] = lim_sh[1];
      4'd6: r[W-1:0] = dn_sh[2];
      4'd7: r[W-1:0] = lim_sh[2];
      default: r = '0;
    endcase
    return r;
  endfunction

  // Byte-lane merge of new write data over the current register value
  function automatic logic [DW-1:0] strb_merge(input logic [DW-1:0] old,
                                               input logic [DW-1:0] din,
                                               input logic [BW-1:0] strb);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++) begin
      if (strb[b]) r[b*8 +: 8] = din[b*8 +: 8];
    end
    return r;
  endfunction

  assign waddr = s00_axi_awaddr[5:2];
  assign raddr = s00_axi_araddr[5:2];
  assign wr_hs = s00_axi_awready && s00_axi_awvalid && s00_axi_wvalid;
  assign rd_hs = s00_axi_arready && s00_axi_arvalid;

  always_comb begin
    wr_word = strb_merge(reg_rd(waddr), s00_axi_wdata, s00_axi_wstrb);
  end

  assign s00_axi_bresp = 2'b00;
  assign s00_axi_rresp = 2'b00;

  // Write channel: awready/wready pulse together, response follows next cycle
  always_ff @(posedge s00_axi_aclk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      s00_axi_awready <= 1'b0;
      s00_axi_wready  <= 1'b0;
      s00_axi_bvalid  <= 1'b0;
    end else begin
      s00_axi_awready <= !s00_axi_awready && s00_axi_awvalid && s00_axi_wvalid && !s00_axi_bvalid;
      s00_axi_wready  <= !s00_axi_awready && s00_axi_awvalid && s00_axi_wvalid && !s00_axi_bvalid;
      if (wr_hs)               s00_axi_bvalid <= 1'b1;
      else if (s00_axi_bready) s00_axi_bvalid <= 1'b0;
    end
  end

  // Read channel: rdata samples the pre-write register state on the handshake edge
  always_ff @(posedge s00_axi_aclk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      s00_axi_arready <= 1'b0;
      s00_axi_rvalid  <= 1'b0;
      s00_axi_rdata   <= '0;
    end else begin
      s00_axi_arready <= !s00_axi_arready && s00_axi_arvalid && !s00_axi_rvalid;
      if (rd_hs) begin
        s00_axi_rvalid <= 1'b1;
        s00_axi_rdata  <= reg_rd(raddr);
      end else if (s00_axi_rready) begin
        s00_axi_rvalid <= 1'b0;
      end
    end
  end

  // Register writes (control and shadow registers)
  always_ff @(posedge s00_axi_aclk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      cst <= '0;
      for (int i = 0; i < 3; i++) begin
        dn_sh[i]  <= '0;
        lim_sh[i] <= '0;
      end
    end else if (wr_hs) begin
      case (waddr)
        4'd0: cst       <= wr_word[6:0] & CST_MASK;
        4'd2: dn_sh[0]  <= wr_word[W-1:0];
        4'd3: lim_sh[0] <= wr_word[W-1:0];
        4'd4: dn_sh[1]  <= wr_word[W-1:0];
        4'd5: lim_sh[1] <= wr_word[W-1:0];
        4'd6: dn_sh[2]  <= wr_word[W-1:0];
        4'd7: lim_sh[2] <= wr_word[W-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      wrap[i] = cst[i] && (cnt[i] == lim_act[i]);
    end
  end

  // Channel counters; active DN/LIM track the shadows while stopped and
  // refresh at each wrap while running
  always_ff @(posedge s00_axi_aclk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      pwm_out <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt[i]     <= '0;
        dn_act[i]  <= '0;
        lim_act[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!cst[i] || wrap[i]) begin
          cnt[i]     <= '0;
          dn_act[i]  <= dn_sh[i];
          lim_act[i] <= lim_sh[i];
        end else begin
          cnt[i] <= cnt[i] + W'(1);
        end
        pwm_out[i] <= cst[i] && (cnt[i] < dn_act[i]);
      end
    end
  end

`ifdef MYPWM_IRQ_EN
  logic [2:0] stat_clr;

  always_comb begin
    stat_clr = '0;
    if (wr_hs && (waddr == 4'd1) && s00_axi_wstrb[0]) stat_clr = s00_axi_wdata[2:0];
  end

  // Sticky wrap flags; a wrap in the same cycle as a clear keeps the flag set
  always_ff @(posedge s00_axi_aclk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      stat <= '0;
      irq  <= 1'b0;
    end else begin
      stat <= (stat & ~stat_clr) | wrap;
      irq  <= |(stat & cst[6:4]);
    end
  end
`else
  assign stat = '0;
`endif

  logic unused_bits;
  assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot,
                         s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

endmodule

// File: tb/tb_my_pwm_v1_0.sv
`timescale 1ns/1ps
module tb_my_pwm_v1_0;

  logic        clk;
  logic        aresetn;
  logic [5:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [5:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [2:0]  pwm_out;
`ifdef MYPWM_IRQ_EN
  logic        irq;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  int          hi_q[$];
  int          lo_q[$];

  my_pwm_v1_0 #(.W(12), .C_S00_AXI_DATA_WIDTH(32), .C_S00_AXI_ADDR_WIDTH(6)) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (aresetn),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (awprot),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (arprot),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .pwm_out         (pwm_out)
`ifdef MYPWM_IRQ_EN
    ,
    .irq             (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic sb_check(input string tag, input logic [31:0] got);
    logic [31:0] e;
    e = 32'hBAD0_BAD0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk(tag, got, e);
  endtask

  // Run-length monitor of pwm_out[0], sampled mid-cycle
  logic mon_prev = 1'b0;
  int   mon_run  = 0;
  always @(negedge clk) begin
    if (pwm_out[0] == mon_prev) begin
      mon_run++;
    end else begin
      if (mon_prev) hi_q.push_back(mon_run);
      else          lo_q.push_back(mon_run);
      mon_run  = 1;
      mon_prev = pwm_out[0];
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    int k;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while (!awready && k < 50);
    chk("awready", {31'b0, awready}, 32'd1);
    chk("wready",  {31'b0, wready},  32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bvalid", {31'b0, bvalid}, 32'd1);
    chk("bresp",  {30'b0, bresp},  32'd0);
  endtask

  task automatic axi_read(input logic [5:0] a, input logic [31:0] e, input string tag);
    int k;
    sb_push(e);
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while (!arready && k < 50);
    chk("arready", {31'b0, arready}, 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("rvalid", {31'b0, rvalid}, 32'd1);
    sb_check(tag, rdata);
    chk("rresp", {30'b0, rresp}, 32'd0);
  endtask

  task automatic wait_runs(input int nh, input int nl);
    int k;
    k = 0;
    while ((hi_q.size() < nh || lo_q.size() < nl) && k < 3000) begin
      @(posedge clk); k++;
    end
    #1;
  endtask

  function automatic int q_at(input int which, input int idx);
    if (which == 1) return (hi_q.size() > idx) ? hi_q[idx] : -1;
    return (lo_q.size() > idx) ? lo_q[idx] : -1;
  endfunction

  task automatic wait_level(input logic v);
    int k;
    k = 0;
    while (pwm_out[0] !== v && k < 1000) begin
      @(posedge clk); #1; k++;
    end
  endtask

  initial begin
    int c;
    aresetn = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b1; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
    #23;
    chk("rst_pwm",   {29'b0, pwm_out}, 32'd0);
    chk("rst_hs",    {27'b0, awready, wready, bvalid, arready, rvalid}, 32'd0);
    chk("rst_resp",  {28'b0, bresp, rresp}, 32'd0);
`ifdef MYPWM_IRQ_EN
    chk("rst_irq",   {31'b0, irq}, 32'd0);
`endif
    @(negedge clk); aresetn = 1'b1;
    cycles(5);

    for (int a = 0; a < 8; a++) axi_read(6'(a * 4), 32'd0, "rst_reg");

    // Unmapped offset ignores writes
    axi_write(6'h20, 32'hDEAD_BEEF, 4'hF);
    axi_read(6'h20, 32'd0, "unmapped");

    // Basic PWM: DN0=80, LIM0=255
    axi_write(6'h08, 32'd80, 4'hF);
    axi_write(6'h0C, 32'd255, 4'hF);
    axi_write(6'h00, 32'h7, 4'hF);
    axi_read(6'h00, 32'h7, "cst_rd");
    hi_q.delete(); lo_q.delete();
    wait_runs(2, 2);
    sb_push(32'd80);  sb_check("pwm0_high", q_at(1, 1));
    sb_push(32'd176); sb_check("pwm0_low",  q_at(0, 1));
    c = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (pwm_out[2:1] != 2'b00) c++;
    end
    chk("pwm21_low", c, 0);

    // Mid-period DN rewrite: this period keeps 80, next period uses 20
    wait_level(1'b0);
    wait_level(1'b1);
    hi_q.delete(); lo_q.delete();
    axi_write(6'h08, 32'd20, 4'hF);
    axi_read(6'h08, 32'd20, "dn0_shadow_rd");
    wait_runs(2, 0);
    sb_push(32'd80); sb_check("pwm0_cur_period", q_at(1, 0));
    sb_push(32'd20); sb_check("pwm0_next_period", q_at(1, 1));

    // DN0=0 gives constant low
    axi_write(6'h08, 32'd0, 4'hF);
    cycles(300);
    c = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (pwm_out[0]) c++;
    end
    chk("dn0_zero_highs", c, 0);

    // DN0 > LIM0 gives constant high
    axi_write(6'h08, 32'd300, 4'hF);
    cycles(300);
    c = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (!pwm_out[0]) c++;
    end
    chk("dn0_over_lim_lows", c, 0);

    // Field width truncation and byte strobes
    axi_write(6'h14, 32'hFFFF_FFFF, 4'hF);
    axi_read(6'h14, 32'h0000_0FFF, "lim1_trunc");
    axi_write(6'h14, 32'h1234_5634, 4'b0001);
    axi_read(6'h14, 32'h0000_0F34, "lim1_strb");
    axi_write(6'h10, 32'h0000_0A00, 4'b0010);
    axi_read(6'h10, 32'h0000_0A00, "dn1_strb");
`ifndef MYPWM_IRQ_EN
    axi_read(6'h04, 32'd0, "stat_absent");
    axi_write(6'h00, 32'h77, 4'hF);
    axi_read(6'h00, 32'h07, "cst_irq_absent");
`endif

    // Clearing the enable forces the output low
    axi_write(6'h00, 32'h7, 4'hF);
    cycles(3);
    chk("pwm0_before_dis", {31'b0, pwm_out[0]}, 32'd1);
    axi_write(6'h00, 32'h6, 4'hF);
    cycles(1);
    chk("pwm0_after_dis", {31'b0, pwm_out[0]}, 32'd0);

`ifdef MYPWM_IRQ_EN
    axi_write(6'h00, 32'h0, 4'hF);
    axi_write(6'h04, 32'h7, 4'hF);
    axi_write(6'h0C, 32'd15, 4'hF);
    axi_write(6'h00, 32'h11, 4'hF);
    cycles(40);
    chk("irq_set", {31'b0, irq}, 32'd1);
    axi_read(6'h04, 32'h1, "stat_rd");
    axi_read(6'h00, 32'h11, "cst_irq_rd");
    axi_write(6'h00, 32'h10, 4'hF);
    cycles(3);
    chk("irq_sticky", {31'b0, irq}, 32'd1);
    axi_write(6'h04, 32'h1, 4'hF);
    cycles(2);
    chk("irq_cleared", {31'b0, irq}, 32'd0);
    axi_write(6'h00, 32'h11, 4'hF);
    cycles(40);
    chk("irq_reset_on_wrap", {31'b0, irq}, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
